l1_mem_arbiter: RTL

- Shares the single L2/physical-memory line port between the L1 instruction cache miss path and the L1 data cache miss/writeback path.
- Sits below both L1 caches: icache_resp/dcache_resp seen by the CPU datapath depend on its grants.
- Non-preemptive, one transaction in flight. Round-robin when both sides request in the same cycle.
- Counts simultaneous-request conflicts for performance debug.

---
 rtl/l1_mem_arbiter_pkg.sv | 24 ++
 rtl/l1_mem_arbiter_sat_counter.sv | 26 ++
 rtl/l1_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the L1 memory arbiter: FSM state encoding, grant owner
// encoding and the round-robin pick used when both L1 caches request.
package l1_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2,
      ARB_RELEASE = 2'd3
   } lc3b_arb_state;

   typedef logic lc3b_arb_owner;

   localparam lc3b_arb_owner OWNER_I = 1'b0;
   localparam lc3b_arb_owner OWNER_D = 1'b1;

   // D wins when it is alone, or on a tie when I was the last side served.
   function automatic logic arb_pick_d(input logic          req_i,
                                       input logic          req_d,
                                       input lc3b_arb_owner last_grant);
      return req_d & (~req_i | (last_grant == OWNER_I));
   endfunction

endpackage

// File: rtl/l1_mem_arbiter_sat_counter.sv
// Saturating up-counter for performance monitoring; cleared only by reset.
module l1_mem_arbiter_sat_counter #(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // Count one per inc pulse, holding once every bit is set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + WIDTH'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbiter sharing the single L2 line port between the icache fill path and
// the dcache fill/writeback path. One transaction in flight, no preemption,
// round-robin on simultaneous requests, with a conflict counter for debug.
module l1_mem_arbiter
   import l1_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128,
   parameter int CNT_WIDTH  = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_mem_read,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   output logic [LINE_WIDTH-1:0] i_mem_rdata,
   output logic                  i_mem_resp,
   input  logic                  d_mem_read,
   input  logic                  d_mem_write,
   input  logic [ADDR_WIDTH-1:0] d_mem_addr,
   input  logic [LINE_WIDTH-1:0] d_mem_wdata,
   output logic [LINE_WIDTH-1:0] d_mem_rdata,
   output logic                  d_mem_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_addr,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  conflict_count
);

   lc3b_arb_state         r_state;
   lc3b_arb_state         w_next_state;
   lc3b_arb_owner         r_last_grant;
   logic                  r_l2_read;
   logic                  r_l2_write;
   logic [ADDR_WIDTH-1:0] r_l2_addr;
   logic [LINE_WIDTH-1:0] r_l2_wdata;
   logic                  w_i_req;
   logic                  w_d_req;
   logic                  w_conflict;
   logic                  w_grant_d;
   logic                  w_i_resp;
   logic                  w_d_resp;
   logic                  w_busy;

   // Request terms, tie detection and the round-robin decision.
   always_comb begin
      w_i_req    = i_mem_read;
      w_d_req    = d_mem_read | d_mem_write;
      w_conflict = (r_state == ARB_IDLE) & w_i_req & w_d_req;
      w_grant_d  = arb_pick_d(w_i_req, w_d_req, r_last_grant);
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: grant from IDLE, finish on l2_resp, one idle RELEASE cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant_d) begin
               w_next_state = ARB_SERVE_D;
            end else if (w_i_req) begin
               w_next_state = ARB_SERVE_I;
            end else begin
               w_next_state = ARB_IDLE;
            end
         end
         ARB_SERVE_I, ARB_SERVE_D: begin
            if (l2_resp) begin
               w_next_state = ARB_RELEASE;
            end else begin
               w_next_state = r_state;
            end
         end
         ARB_RELEASE: w_next_state = ARB_IDLE;
         default:     w_next_state = ARB_IDLE;
      endcase
   end

   // Latch address/data and raise strobes on grant; drop strobes on l2_resp.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_l2_read    <= 1'b0;
         r_l2_write   <= 1'b0;
         r_l2_addr    <= '0;
         r_l2_wdata   <= '0;
         r_last_grant <= OWNER_I;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_grant_d) begin
                  r_l2_addr    <= d_mem_addr;
                  r_l2_wdata   <= d_mem_wdata;
                  r_l2_write   <= d_mem_write;
                  r_l2_read    <= ~d_mem_write;
                  r_last_grant <= OWNER_D;
               end else if (w_i_req) begin
                  r_l2_addr    <= i_mem_addr;
                  r_l2_read    <= 1'b1;
                  r_l2_write   <= 1'b0;
                  r_last_grant <= OWNER_I;
               end else begin
                  r_l2_read    <= 1'b0;
                  r_l2_write   <= 1'b0;
               end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
               if (l2_resp) begin
                  r_l2_read  <= 1'b0;
                  r_l2_write <= 1'b0;
               end else begin
                  r_l2_read  <= r_l2_read;
                  r_l2_write <= r_l2_write;
               end
            end
            default: begin
               r_l2_read  <= 1'b0;
               r_l2_write <= 1'b0;
            end
         endcase
      end
   end

   // Completion pulse goes only to the owner; busy outside IDLE.
   always_comb begin
      w_i_resp = 1'b0;
      w_d_resp = 1'b0;
      w_busy   = 1'b1;
      case (r_state)
         ARB_IDLE:    w_busy   = 1'b0;
         ARB_SERVE_I: w_i_resp = l2_resp;
         ARB_SERVE_D: w_d_resp = l2_resp;
         ARB_RELEASE: w_busy   = 1'b1;
         default:     w_busy   = 1'b1;
      endcase
   end

   l1_mem_arbiter_sat_counter #(
      .WIDTH   (CNT_WIDTH)
   ) u_conflict_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_conflict),
      .o_count (conflict_count)
   );

   assign i_mem_resp  = w_i_resp;
   assign d_mem_resp  = w_d_resp;
   assign i_mem_rdata = l2_rdata;
   assign d_mem_rdata = l2_rdata;
   assign l2_read     = r_l2_read;
   assign l2_write    = r_l2_write;
   assign l2_addr     = r_l2_addr;
   assign l2_wdata    = r_l2_wdata;
   assign busy        = w_busy;

endmodule
